ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Runs alongside the ps2scan receiver on the same ps2k_clk/ps2k_data open-drain pair. The top level ties pads low when the matching *_oe is 1 and leaves them high-Z otherwise.
- Handles clock inhibit, request-to-send, bit shifting on device clock edges, parity, stop, ACK check and timeout.
- While busy=1 the top level gates the receiver off.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- INHIBIT_CYC, 6000, cycles ps2k_clk is held low before request-to-send (120 us at 50 MHz).
- RTS_CYC, 1000, cycles data and clock are both low before clock release (20 us).
- TIMEOUT_CYC, 750000, maximum cycles from clock release to ACK sample (15 ms).
- FILT_LEN, 4, consecutive equal synchronized samples required to accept a ps2k_clk level change.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  command byte, captured on the tx_start cycle
- tx_start  in  1  one-cycle request; ignored while busy=1
- ps2k_clk_i  in  1  ps2k_clk pad input (asynchronous)
- ps2k_data_i  in  1  ps2k_data pad input (asynchronous)
- ps2k_clk_oe  out  1  1 = drive ps2k_clk low
- ps2k_data_oe  out  1  1 = drive ps2k_data low
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse: transfer finished
- ack_ok  out  1  valid with done: 1 = device ACK seen
- err  out  1  one-cycle pulse: timeout; never asserted together with done

Behaviour:
- Reset, asynchronous: state IDLE; ps2k_clk_oe=0, ps2k_data_oe=0, busy=0, done=0, ack_ok=0, err=0; all counters and the shift register cleared. Reset mid-transfer releases both lines immediately.
- Input conditioning: 2-FF synchronizer on both pad inputs.
  - ps2k_clk then passes the FILT_LEN glitch filter.
  - A falling edge (fall) is a filtered 1->0 transition, flagged for one cycle.
- Parity: odd, computed on capture as ~^tx_data. Frame sent = {stop=1, parity, tx_data[7:0]}, LSB first.
- IDLE:
  - tx_start=1 -> latch tx_data, busy=1, ps2k_clk_oe=1, go to INHIBIT.
- INHIBIT: count INHIBIT_CYC cycles, then ps2k_data_oe=1 (start bit 0) and go to RTS.
- RTS: count RTS_CYC cycles, then ps2k_clk_oe=0, clear the timeout counter and bit index, go to SHIFT.
- SHIFT: on each fall, bit index n = 0..9:
  - n=0..7: ps2k_data_oe = ~tx_data[n].
  - n=8: ps2k_data_oe = ~parity.
  - n=9: ps2k_data_oe=0 (stop; line released), go to ACK.
  - The output register updates in the cycle after fall is flagged, well inside the device's low clock phase.
- ACK:
  - On the next fall, sample the synchronized data: ack_ok = ~data (0 on the line = ACK).
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - When filtered clk=1 and synchronized data=1 for FILT_LEN consecutive cycles -> done pulse, busy=0, IDLE.
  - ack_ok holds its value until the next tx_start.
- Timeout:
  - Counter runs in SHIFT, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYC -> both oe=0, err pulse, ack_ok=0, busy=0, IDLE. No done pulse on timeout.
  - If timeout and the final idle detection land in the same cycle, timeout wins.
- Edge cases:
  - Falls seen during INHIBIT or RTS are ignored. The host drives the clock low there, so no edges are expected.
  - tx_start while busy=1 is ignored; no queuing.
  - tx_start in the same cycle as done is ignored; busy drops one cycle later.
  - tx_start again after done/err starts a new transfer from INHIBIT.
- Latency:
  - tx_start -> ps2k_clk_oe=1 takes 1 cycle.
  - ps2k_clk_oe=1 -> ps2k_data_oe=1 takes INHIBIT_CYC cycles.
  - ps2k_data_oe=1 -> clock release takes RTS_CYC cycles.

Test Plan (sim parameters: INHIBIT_CYC=20, RTS_CYC=5, TIMEOUT_CYC=2000, FILT_LEN=2; device model clocks at 40-cycle period, samples data on rising edges, drives ACK):
- Send tx_data=0xED.
  - Required: clk_oe low for 20 cycles before data_oe rises.
  - Device samples 0, 1,0,1,1,0,1,1,1, parity 1, stop 1; model ACKs.
  - Result: done=1 and ack_ok=1 for one cycle, busy falls the next cycle.
- Send 0xF4 (five ones): parity sampled = 0; frame 0,0,0,1,0,1,1,1,1,0,1; ack_ok=1.
- Device model omits ACK (leaves data high) -> done with ack_ok=0, err=0.
- Device model never clocks after release -> err pulse exactly 2000 cycles after clk_oe falls; both oe=0, busy=0, no done.
- Reset mid-SHIFT after the 4th fall -> both oe=0 and busy=0 asynchronously. A new tx_start=0x55 then completes with ack_ok=1.
- tx_start pulsed with 0x00 during busy on a 0xFF transfer:
  - Device receives 0xFF with parity 1.
  - The 0x00 request causes no second transfer.
  - Add a 1-cycle glitch on ps2k_clk_i mid-SHIFT: no bit slip.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard
// over the shared open-drain ps2k_clk/ps2k_data pair: clock inhibit,
// request-to-send, 8 data bits + odd parity + stop shifted on device clock
// falls, ACK sample, return-to-idle detection, and a transfer timeout.
module ps2_host_tx #(
  parameter int CLK_FREQ    = 50000000,
  parameter int INHIBIT_CYC = 6000,
  parameter int RTS_CYC     = 1000,
  parameter int TIMEOUT_CYC = 750000,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2k_clk_i,
  input  logic       ps2k_data_i,
  output logic       ps2k_clk_oe,
  output logic       ps2k_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int CNT_MAX = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int FC_W    = $clog2(FILT_LEN + 1);

  if (CLK_FREQ <= 0 || FILT_LEN < 1 || INHIBIT_CYC < 1 || RTS_CYC < 1 ||
      TIMEOUT_CYC < 1) begin : g_bad_param
    $error("ps2_host_tx: parameters must be positive");
  end

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE
  } state_t;

  logic [1:0]      clk_sync, data_sync;
  logic            clk_s, data_s;
  logic            clk_filt, fall;
  logic [FC_W-1:0] filt_cnt;

  state_t          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic [3:0]      bit_idx, bit_idx_n;
  logic [8:0]      shreg, shreg_n;      // {parity, data[7:0]}
  logic [FC_W-1:0] idle_cnt, idle_cnt_n;
  logic            clk_oe_n, data_oe_n, busy_n, done_n, ack_ok_n, err_n;
  logic            timeout;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Two-stage synchronizers for the asynchronous pad inputs (idle level high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value,
      // so the two stages really form a two-cycle pipeline.
      clk_sync  <= {clk_sync[0], ps2k_clk_i};
      data_sync <= {data_sync[0], ps2k_data_i};
    end
  end

  // Glitch filter on the clock: accept a level only after FILT_LEN equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
        fall     <= clk_filt;           // only a 1->0 change is a fall
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // State and datapath register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      to_cnt       <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      idle_cnt     <= '0;
      ps2k_clk_oe  <= 1'b0;
      ps2k_data_oe <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ack_ok       <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      to_cnt       <= to_cnt_n;
      bit_idx      <= bit_idx_n;
      shreg        <= shreg_n;
      idle_cnt     <= idle_cnt_n;
      ps2k_clk_oe  <= clk_oe_n;
      ps2k_data_oe <= data_oe_n;
      busy         <= busy_n;
      done         <= done_n;
      ack_ok       <= ack_ok_n;
      err          <= err_n;
    end
  end

  // Next-state and output logic for the transfer sequence.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_n    = state;
    cnt_n      = cnt;
    to_cnt_n   = to_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    idle_cnt_n = idle_cnt;
    clk_oe_n   = ps2k_clk_oe;
    data_oe_n  = ps2k_data_oe;
    busy_n     = busy;
    ack_ok_n   = ack_ok;
    done_n     = 1'b0;
    err_n      = 1'b0;
    timeout    = 1'b0;

    if (state == SHIFT || state == ACK || state == WAIT_IDLE) begin
      to_cnt_n = to_cnt + 1'b1;
      timeout  = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    end

    case (state)
      IDLE: begin
        // busy is still high for the cycle done is shown, so a start there is dropped
        busy_n = 1'b0;
        if (tx_start && !busy) begin
          shreg_n  = {~^tx_data, tx_data};
          busy_n   = 1'b1;
          clk_oe_n = 1'b1;
          ack_ok_n = 1'b0;
          cnt_n    = '0;
          state_n  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == CNT_W'(INHIBIT_CYC - 1)) begin
          cnt_n     = '0;
          data_oe_n = 1'b1;             // start bit
          state_n   = RTS;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RTS: begin
        if (cnt == CNT_W'(RTS_CYC - 1)) begin
          cnt_n     = '0;
          clk_oe_n  = 1'b0;
          to_cnt_n  = '0;
          bit_idx_n = '0;
          state_n   = SHIFT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (fall) begin
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 4'd9) begin
            data_oe_n = 1'b0;           // stop bit: line released
            state_n   = ACK;
          end else begin
            data_oe_n = ~shreg[bit_idx];
          end
        end
      end
      ACK: begin
        if (fall) begin
          ack_ok_n   = ~data_s;         // device pulls data low to acknowledge
          idle_cnt_n = '0;
          state_n    = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && data_s) begin
          if (idle_cnt == FC_W'(FILT_LEN - 1)) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            idle_cnt_n = idle_cnt + 1'b1;
          end
        end else begin
          idle_cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Timeout overrides everything, including a same-cycle idle detection.
    if (timeout) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      err_n     = 1'b1;
      done_n    = 1'b0;
      ack_ok_n  = 1'b0;
      busy_n    = 1'b0;
      state_n   = IDLE;
    end
  end

endmodule
